// File: rtl/rotary_value_ctrl.sv
// Rotary encoder value controller: bounded value register with saturate/wrap stepping,
// host load and a valid/ack change-event handshake. Define ROTARY_ACCEL_EN for rotation acceleration.
module rotary_value_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MIN         = 0,
  parameter int MAX         = 255,
  parameter int RESET_VALUE = 0,
  parameter int WRAP        = 0,
  parameter int ACC_WINDOW  = 16,
  parameter int ACC_STEP    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_step_cw,
  input  logic             i_load,
  input  logic [WIDTH-1:0] iv_load_value,
  output logic [WIDTH-1:0] ov_value,
  output logic             o_at_min,
  output logic             o_at_max,
  output logic             o_evt_valid,
  output logic             o_evt_cw,
  output logic             o_evt_sat,
  output logic             o_evt_multi,
  input  logic             i_evt_ack
);

  localparam int RESET_CLAMPED = (RESET_VALUE < MIN) ? MIN :
                                 (RESET_VALUE > MAX) ? MAX : RESET_VALUE;
  localparam int XW = WIDTH + 2;

  localparam logic [WIDTH-1:0]     MIN_V    = WIDTH'(MIN);
  localparam logic [WIDTH-1:0]     MAX_V    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0]     RESET_V  = WIDTH'(RESET_CLAMPED);
  localparam logic signed [XW-1:0] MIN_X    = XW'(MIN);
  localparam logic signed [XW-1:0] MAX_X    = XW'(MAX);
  localparam logic signed [XW-1:0] STEP_ONE = XW'(1);
  localparam logic signed [XW-1:0] STEP_ACC = XW'(ACC_STEP);
  localparam bit                   ACC_CFG_OK = (ACC_WINDOW > 0) && (ACC_STEP > 0);

  typedef enum logic {
    IDLE,
    PENDING
  } evt_state_t;

  evt_state_t state_q, state_d;

  logic [WIDTH-1:0]     value_q;
  logic [WIDTH-1:0]     step_value;
  logic                 step_sat;
  logic                 step_acc;
  logic                 accel_hit;
  logic signed [XW-1:0] step_mag;
  logic signed [XW-1:0] cur_x;
  logic signed [XW-1:0] sum_x;
  logic                 evt_cw_q;
  logic                 evt_sat_q;
  logic                 evt_multi_q;

  // A load in the same cycle swallows the step entirely.
  assign step_acc = i_step && !i_load;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  // Widened signed arithmetic so over/underflow past either bound is visible before folding.
  always_comb begin
    step_mag   = (accel_hit && ACC_CFG_OK) ? STEP_ACC : STEP_ONE;
    cur_x      = $signed({2'b00, value_q});
    sum_x      = i_step_cw ? (cur_x + step_mag) : (cur_x - step_mag);
    step_value = sum_x[WIDTH-1:0];
    step_sat   = 1'b0;
    if (sum_x > MAX_X) begin
      step_sat   = 1'b1;
      step_value = (WRAP != 0) ? MIN_V : MAX_V;
    end else if (sum_x < MIN_X) begin
      step_sat   = 1'b1;
      step_value = (WRAP != 0) ? MAX_V : MIN_V;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      value_q <= RESET_V;
    else if (i_load)   value_q <= clamp_load(iv_load_value);
    else if (step_acc) value_q <= step_value;
  end

`ifdef ROTARY_ACCEL_EN
  localparam int CNT_W = (ACC_WINDOW > 0) ? $clog2(ACC_WINDOW + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ACC_WINDOW);

  logic [CNT_W-1:0] gap_cnt;
  logic             prev_valid;
  logic             prev_cw;

  // prev_valid drops on load so the first step after a load is never accelerated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gap_cnt    <= CNT_SAT;
      prev_valid <= 1'b0;
      prev_cw    <= 1'b0;
    end else if (i_load) begin
      gap_cnt    <= '0;
      prev_valid <= 1'b0;
    end else if (step_acc) begin
      gap_cnt    <= '0;
      prev_valid <= 1'b1;
      prev_cw    <= i_step_cw;
    end else if (gap_cnt != CNT_SAT) begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

  assign accel_hit = prev_valid && (prev_cw == i_step_cw) && (gap_cnt < CNT_SAT);
`else
  assign accel_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_acc) state_d = PENDING;
      PENDING: if (i_evt_ack && !step_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A step arriving with the ack starts a fresh event rather than folding into the old one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_cw_q    <= 1'b0;
      evt_sat_q   <= 1'b0;
      evt_multi_q <= 1'b0;
    end else if (step_acc) begin
      evt_cw_q    <= i_step_cw;
      evt_sat_q   <= step_sat;
      evt_multi_q <= (state_q == PENDING) && !i_evt_ack;
    end else if ((state_q == PENDING) && i_evt_ack) begin
      evt_cw_q    <= 1'b0;
      evt_sat_q   <= 1'b0;
      evt_multi_q <= 1'b0;
    end
  end

  always_comb begin
    ov_value    = value_q;
    o_at_min    = (value_q == MIN_V);
    o_at_max    = (value_q == MAX_V);
    o_evt_valid = (state_q == PENDING);
    o_evt_cw    = evt_cw_q;
    o_evt_sat   = evt_sat_q;
    o_evt_multi = evt_multi_q;
  end

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Self-checking bench for rotary_value_ctrl: a saturating and a wrapping instance share stimulus
// and are compared every cycle against an integer reference model.
module tb_rotary_value_ctrl;

  localparam int W     = 4;
  localparam int MIN_V = 2;
  localparam int MAX_V = 12;
  localparam int ACC_W = 16;
  localparam int ACC_S = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         step       = 1'b0;
  logic         step_cw    = 1'b0;
  logic         load       = 1'b0;
  logic         evt_ack    = 1'b0;
  logic [W-1:0] load_value = '0;

  logic [W-1:0] dut_value  [2];
  logic         dut_at_min [2];
  logic         dut_at_max [2];
  logic         dut_valid  [2];
  logic         dut_cw     [2];
  logic         dut_sat    [2];
  logic         dut_multi  [2];

  int vectors     = 0;
  int miscompares = 0;

  int m_val   [2];
  bit m_pend  [2];
  bit m_cw    [2];
  bit m_sat   [2];
  bit m_multi [2];
`ifdef ROTARY_ACCEL_EN
  bit m_prev_valid [2];
  bit m_prev_cw    [2];
  int m_gap        [2];
`endif

  always #5 clk = ~clk;

  rotary_value_ctrl #(.WIDTH(W), .MIN(MIN_V), .MAX(MAX_V), .RESET_VALUE(0), .WRAP(0),
                      .ACC_WINDOW(ACC_W), .ACC_STEP(ACC_S)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_step_cw(step_cw), .i_load(load),
    .iv_load_value(load_value), .ov_value(dut_value[0]), .o_at_min(dut_at_min[0]),
    .o_at_max(dut_at_max[0]), .o_evt_valid(dut_valid[0]), .o_evt_cw(dut_cw[0]),
    .o_evt_sat(dut_sat[0]), .o_evt_multi(dut_multi[0]), .i_evt_ack(evt_ack));

  rotary_value_ctrl #(.WIDTH(W), .MIN(MIN_V), .MAX(MAX_V), .RESET_VALUE(0), .WRAP(1),
                      .ACC_WINDOW(ACC_W), .ACC_STEP(ACC_S)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_step(step), .i_step_cw(step_cw), .i_load(load),
    .iv_load_value(load_value), .ov_value(dut_value[1]), .o_at_min(dut_at_min[1]),
    .o_at_max(dut_at_max[1]), .o_evt_valid(dut_valid[1]), .o_evt_cw(dut_cw[1]),
    .o_evt_sat(dut_sat[1]), .o_evt_multi(dut_multi[1]), .i_evt_ack(evt_ack));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]   = clampi(0);
      m_pend[k]  = 1'b0;
      m_cw[k]    = 1'b0;
      m_sat[k]   = 1'b0;
      m_multi[k] = 1'b0;
`ifdef ROTARY_ACCEL_EN
      m_prev_valid[k] = 1'b0;
      m_prev_cw[k]    = 1'b0;
      m_gap[k]        = ACC_W;
`endif
    end
  endfunction

  // Instance 0 saturates at the bounds, instance 1 wraps to the opposite bound.
  function automatic void modelClock(input bit st, input bit cw, input bit ld, input int lv, input bit ack);
    int  s;
    int  nv;
    bit  clipped;
    for (int k = 0; k < 2; k++) begin
      if (ld) begin
        m_val[k] = clampi(lv);
`ifdef ROTARY_ACCEL_EN
        m_prev_valid[k] = 1'b0;
        m_gap[k]        = 0;
`endif
        if (m_pend[k] && ack) begin
          m_pend[k] = 1'b0; m_cw[k] = 1'b0; m_sat[k] = 1'b0; m_multi[k] = 1'b0;
        end
      end else if (st) begin
        s = 1;
`ifdef ROTARY_ACCEL_EN
        if (m_prev_valid[k] && (m_prev_cw[k] == cw) && (m_gap[k] < ACC_W)) s = ACC_S;
        m_prev_valid[k] = 1'b1;
        m_prev_cw[k]    = cw;
        m_gap[k]        = 0;
`endif
        nv      = cw ? m_val[k] + s : m_val[k] - s;
        clipped = 1'b0;
        if (nv > MAX_V) begin
          clipped = 1'b1;
          nv      = (k == 1) ? MIN_V : MAX_V;
        end else if (nv < MIN_V) begin
          clipped = 1'b1;
          nv      = (k == 1) ? MAX_V : MIN_V;
        end
        m_multi[k] = m_pend[k] && !ack;
        m_pend[k]  = 1'b1;
        m_cw[k]    = cw;
        m_sat[k]   = clipped;
        m_val[k]   = nv;
      end else begin
        if (m_pend[k] && ack) begin
          m_pend[k] = 1'b0; m_cw[k] = 1'b0; m_sat[k] = 1'b0; m_multi[k] = 1'b0;
        end
`ifdef ROTARY_ACCEL_EN
        if (m_gap[k] < ACC_W) m_gap[k]++;
`endif
      end
    end
  endfunction

  task automatic compareModel();
    string pre;
    for (int k = 0; k < 2; k++) begin
      pre = (k == 1) ? "wrap" : "sat";
      checkOutput({pre, ".value"},  32'(dut_value[k]),  32'(m_val[k]));
      checkOutput({pre, ".at_min"}, 32'(dut_at_min[k]), (m_val[k] == MIN_V) ? 1 : 0);
      checkOutput({pre, ".at_max"}, 32'(dut_at_max[k]), (m_val[k] == MAX_V) ? 1 : 0);
      checkOutput({pre, ".valid"},  32'(dut_valid[k]),  32'(m_pend[k]));
      checkOutput({pre, ".cw"},     32'(dut_cw[k]),     32'(m_cw[k]));
      checkOutput({pre, ".sat"},    32'(dut_sat[k]),    32'(m_sat[k]));
      checkOutput({pre, ".multi"},  32'(dut_multi[k]),  32'(m_multi[k]));
    end
  endtask

  task automatic applyStimulus(input bit st, input bit cw, input bit ld,
                               input logic [W-1:0] lv, input bit ack);
    step       = st;
    step_cw    = cw;
    load       = ld;
    load_value = lv;
    evt_ack    = ack;
    @(posedge clk);
    modelClock(st, cw, ld, int'(lv), ack);
    #1;
    step    = 1'b0;
    load    = 1'b0;
    evt_ack = 1'b0;
    compareModel();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    bit           r_st, r_cw, r_ld, r_ack;
    logic [W-1:0] r_lv;
    int           step_pct;

    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.value",  32'(dut_value[0]),  2);
    checkOutput("rst.at_min", 32'(dut_at_min[0]), 1);
    checkOutput("rst.valid",  32'(dut_valid[0]),  0);
    compareModel();
    rst_n = 1'b1;
    idleCycles(2);

    // Sweep up past MAX with each event acknowledged.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("sweep.value", 32'(dut_value[0]), (i <= 10) ? 2 + i : 12);
      checkOutput("sweep.sat",   32'(dut_sat[0]),   (i >= 11) ? 1 : 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput("sweep.acked", 32'(dut_valid[0]), 0);
      idleCycles(18);
    end
    checkOutput("sweep.at_max", 32'(dut_at_max[0]), 1);

    applyStimulus(1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("wrap.up.value", 32'(dut_value[1]), 2);
    checkOutput("wrap.up.sat",   32'(dut_sat[1]),   1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("wrap.down.value", 32'(dut_value[1]), 12);
    checkOutput("wrap.down.sat",   32'(dut_sat[1]),   1);

    // Unacknowledged steps fold into one event; ack plus step starts a fresh one.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    idleCycles(19);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    idleCycles(19);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("multi.value", 32'(dut_value[0]), 6);
    checkOutput("multi.valid", 32'(dut_valid[0]), 1);
    checkOutput("multi.cw",    32'(dut_cw[0]),    0);
    checkOutput("multi.multi", 32'(dut_multi[0]), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    checkOutput("ackstep.value", 32'(dut_value[0]), 7);
    checkOutput("ackstep.valid", 32'(dut_valid[0]), 1);
    checkOutput("ackstep.multi", 32'(dut_multi[0]), 0);

    applyStimulus(1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
    checkOutput("loadstep.value", 32'(dut_value[0]), 12);
    checkOutput("loadstep.valid", 32'(dut_valid[0]), 1);
    checkOutput("loadstep.cw",    32'(dut_cw[0]),    1);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.value", 32'(dut_value[0]), 2);
    checkOutput("arst.valid", 32'(dut_valid[0]), 0);
    compareModel();
    #1;
    rst_n = 1'b1;
    idleCycles(2);

`ifdef ROTARY_ACCEL_EN
    begin
      int acc_exp [4] = '{3, 7, 11, 12};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        checkOutput("accel.value", 32'(dut_value[0]), acc_exp[i]);
        checkOutput("accel.sat",   32'(dut_sat[0]),   (i == 3) ? 1 : 0);
        idleCycles(3);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("accel.rev.value", 32'(dut_value[0]), 11);
    end
`endif

    // Randomized traffic alternating between sparse and dense stepping.
    for (int n = 0; n < 1200; n++) begin
      step_pct = (((n / 150) % 2) == 1) ? 75 : 20;
      r_st  = ($urandom_range(99) < step_pct);
      r_cw  = ($urandom_range(99) < (((n / 300) % 2) == 1 ? 25 : 75));
      r_ld  = ($urandom_range(99) < 4);
      r_lv  = W'($urandom);
      r_ack = ($urandom_range(99) < 30);
      applyStimulus(r_st, r_cw, r_ld, r_lv, r_ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
